reg_list_sequencer: RTL and testbench

- Register-list counter for LDM/STM block transfers; sits directly upstream of the microcoded control state machine and supplies its RM_CNTR_DONE input.
- Latches IR[15:0], the P/U bits and the base register value, then walks the set bits lowest-first.
- Per transfer it presents the register index and memory address; it also presents the writeback base value and a PC-in-list flag.
- Microcode holds its loop state while done=0 and jumps to fetch on done=1.

---
 rtl/reg_list_sequencer_if.sv | 30 +++
 rtl/reg_list_sequencer.sv | 89 ++++++++
 tb/tb_reg_list_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/reg_list_sequencer_if.sv
// Bus between the instruction-decode/datapath side and the register-list
// sequencer: load operands and step handshake in, per-transfer index,
// address, writeback value and loop status out.
interface reg_list_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              load;
    logic              step;
    logic [15:0]       reg_list;
    logic              up;
    logic              pre;
    logic [ADDR_W-1:0] base_addr;
    logic [3:0]        reg_idx;
    logic [ADDR_W-1:0] addr;
    logic [4:0]        remaining;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] wb_addr;
    logic              pc_in_list;

    modport master (
        output load, step, reg_list, up, pre, base_addr,
        input  reg_idx, addr, remaining, busy, done, wb_addr, pc_in_list
    );

    modport slave (
        input  load, step, reg_list, up, pre, base_addr,
        output reg_idx, addr, remaining, busy, done, wb_addr, pc_in_list
    );
endinterface

// File: rtl/reg_list_sequencer.sv
// Register-list sequencer for LDM/STM block transfers. Latches the register
// mask, U/P bits and base, then walks set bits lowest-first with an
// ascending word address. Feeds RM_CNTR_DONE of the microcoded controller.
module reg_list_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_list_sequencer_if.slave  bus
);

    // Number of set bits in a 16-bit register mask.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

    logic [15:0]       mask_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [ADDR_W-1:0] wb_addr_p0;
    logic              pc_in_list_p0;

    logic [4:0]        load_cnt;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] wb_next;

    // Load-time address arithmetic: span is 4*n, the block size in bytes.
    always_comb begin
        load_cnt   = popcount16(bus.reg_list);
        span       = ADDR_W'({load_cnt, 2'b00});
        start_addr = bus.base_addr;
        unique case ({bus.up, bus.pre})
            2'b10:   start_addr = bus.base_addr;
            2'b11:   start_addr = bus.base_addr + WORD;
            2'b00:   start_addr = bus.base_addr - span + WORD;
            default: start_addr = bus.base_addr - span;
        endcase
        wb_next = bus.up ? (bus.base_addr + span) : (bus.base_addr - span);
    end

    // Sequence state: load restarts (and beats step), step retires the lowest register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_p0       <= '0;
            addr_p0       <= '0;
            wb_addr_p0    <= '0;
            pc_in_list_p0 <= 1'b0;
        end else if (bus.load) begin
            mask_p0       <= bus.reg_list;
            addr_p0       <= start_addr;
            wb_addr_p0    <= wb_next;
            pc_in_list_p0 <= bus.reg_list[15];
        end else if (bus.step && (mask_p0 != 16'h0000)) begin
            mask_p0 <= mask_p0 & (mask_p0 - 16'h0001);
            addr_p0 <= addr_p0 + WORD;
        end
    end

    logic [4:0] remaining_c;
    assign remaining_c = popcount16(mask_p0);

    assign bus.reg_idx    = lowest_idx(mask_p0);
    assign bus.remaining  = remaining_c;
    assign bus.busy       = (mask_p0 != 16'h0000);
    assign bus.done       = (remaining_c <= 5'd1);
    assign bus.addr       = addr_p0;
    assign bus.wb_addr    = wb_addr_p0;
    assign bus.pc_in_list = pc_in_list_p0;

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Directed bench for reg_list_sequencer: each scenario task drives its
// stimulus and compares outputs against hand-computed values.
module tb_reg_list_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reg_list_sequencer_if #(.ADDR_W(32)) bus ();

    reg_list_sequencer #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus changes and sampling both happen on the falling edge.
    task automatic do_load(input logic [15:0] list, input logic u, input logic p,
                           input logic [31:0] base, input logic with_step);
        bus.load      = 1'b1;
        bus.step      = with_step;
        bus.reg_list  = list;
        bus.up        = u;
        bus.pre       = p;
        bus.base_addr = base;
        @(negedge clk);
        bus.load = 1'b0;
        bus.step = 1'b0;
    endtask

    task automatic do_steps(input int k);
        for (int i = 0; i < k; i++) begin
            bus.step = 1'b1;
            @(negedge clk);
            bus.step = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.reg_idx !== 4'd0) begin errors++; $display("FAIL rst_idx: got %0d expected 0", bus.reg_idx); end
        checks++; if (bus.addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", bus.addr); end
        checks++; if (bus.remaining !== 5'd0) begin errors++; $display("FAIL rst_remaining: got %0d expected 0", bus.remaining); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rst_done: got %b expected 1", bus.done); end
        checks++; if (bus.wb_addr !== 32'h0) begin errors++; $display("FAIL rst_wb: got %h expected 0", bus.wb_addr); end
        checks++; if (bus.pc_in_list !== 1'b0) begin errors++; $display("FAIL rst_pc: got %b expected 0", bus.pc_in_list); end
    endtask

    task automatic test_ia;
        do_load(16'h000E, 1'b1, 1'b0, 32'h1000, 1'b0);
        checks++; if (bus.reg_idx !== 4'd1) begin errors++; $display("FAIL ia_idx0: got %0d expected 1", bus.reg_idx); end
        checks++; if (bus.addr !== 32'h1000) begin errors++; $display("FAIL ia_addr0: got %h expected 1000", bus.addr); end
        checks++; if (bus.remaining !== 5'd3) begin errors++; $display("FAIL ia_rem0: got %0d expected 3", bus.remaining); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL ia_done0: got %b expected 0", bus.done); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ia_busy0: got %b expected 1", bus.busy); end
        checks++; if (bus.wb_addr !== 32'h100C) begin errors++; $display("FAIL ia_wb: got %h expected 100C", bus.wb_addr); end
        do_steps(1);
        checks++; if (bus.reg_idx !== 4'd2 || bus.addr !== 32'h1004 || bus.done !== 1'b0) begin
            errors++; $display("FAIL ia_step1: got idx=%0d addr=%h done=%b expected idx=2 addr=1004 done=0", bus.reg_idx, bus.addr, bus.done); end
        do_steps(1);
        checks++; if (bus.reg_idx !== 4'd3) begin errors++; $display("FAIL ia_idx2: got %0d expected 3", bus.reg_idx); end
        checks++; if (bus.addr !== 32'h1008) begin errors++; $display("FAIL ia_addr2: got %h expected 1008", bus.addr); end
        checks++; if (bus.done !== 1'b1 || bus.remaining !== 5'd1) begin
            errors++; $display("FAIL ia_done2: got done=%b rem=%0d expected done=1 rem=1", bus.done, bus.remaining); end
        do_steps(1);
        checks++; if (bus.busy !== 1'b0 || bus.remaining !== 5'd0 || bus.done !== 1'b1) begin
            errors++; $display("FAIL ia_end: got busy=%b rem=%0d done=%b expected busy=0 rem=0 done=1", bus.busy, bus.remaining, bus.done); end
        checks++; if (bus.wb_addr !== 32'h100C) begin errors++; $display("FAIL ia_wb_hold: got %h expected 100C", bus.wb_addr); end
    endtask

    task automatic test_db_pc;
        do_load(16'h8001, 1'b0, 1'b1, 32'h2000, 1'b0);
        checks++; if (bus.addr !== 32'h1FF8) begin errors++; $display("FAIL db_addr: got %h expected 1FF8", bus.addr); end
        checks++; if (bus.reg_idx !== 4'd0) begin errors++; $display("FAIL db_idx: got %0d expected 0", bus.reg_idx); end
        checks++; if (bus.wb_addr !== 32'h1FF8) begin errors++; $display("FAIL db_wb: got %h expected 1FF8", bus.wb_addr); end
        checks++; if (bus.pc_in_list !== 1'b1) begin errors++; $display("FAIL db_pc: got %b expected 1", bus.pc_in_list); end
        checks++; if (bus.remaining !== 5'd2 || bus.done !== 1'b0) begin
            errors++; $display("FAIL db_rem: got rem=%0d done=%b expected rem=2 done=0", bus.remaining, bus.done); end
        do_steps(1);
        checks++; if (bus.reg_idx !== 4'd15 || bus.addr !== 32'h1FFC || bus.done !== 1'b1) begin
            errors++; $display("FAIL db_step: got idx=%0d addr=%h done=%b expected idx=15 addr=1FFC done=1", bus.reg_idx, bus.addr, bus.done); end
    endtask

    task automatic test_ib_full;
        do_load(16'hFFFF, 1'b1, 1'b1, 32'h0, 1'b0);
        checks++; if (bus.addr !== 32'h4) begin errors++; $display("FAIL ib_addr: got %h expected 4", bus.addr); end
        checks++; if (bus.remaining !== 5'd16) begin errors++; $display("FAIL ib_rem: got %0d expected 16", bus.remaining); end
        checks++; if (bus.wb_addr !== 32'h40) begin errors++; $display("FAIL ib_wb: got %h expected 40", bus.wb_addr); end
        checks++; if (bus.pc_in_list !== 1'b1) begin errors++; $display("FAIL ib_pc: got %b expected 1", bus.pc_in_list); end
        do_steps(14);
        checks++; if (bus.reg_idx !== 4'd14 || bus.remaining !== 5'd2 || bus.done !== 1'b0) begin
            errors++; $display("FAIL ib_14: got idx=%0d rem=%0d done=%b expected idx=14 rem=2 done=0", bus.reg_idx, bus.remaining, bus.done); end
        do_steps(1);
        checks++; if (bus.reg_idx !== 4'd15 || bus.addr !== 32'h40 || bus.done !== 1'b1) begin
            errors++; $display("FAIL ib_15: got idx=%0d addr=%h done=%b expected idx=15 addr=40 done=1", bus.reg_idx, bus.addr, bus.done); end
        do_steps(1);
        checks++; if (bus.busy !== 1'b0 || bus.remaining !== 5'd0) begin
            errors++; $display("FAIL ib_end: got busy=%b rem=%0d expected busy=0 rem=0", bus.busy, bus.remaining); end
    endtask

    task automatic test_da_wrap_empty;
        do_load(16'h0007, 1'b0, 1'b0, 32'h4, 1'b0);
        checks++; if (bus.addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL da_addr: got %h expected FFFFFFFC", bus.addr); end
        checks++; if (bus.wb_addr !== 32'hFFFFFFF8) begin errors++; $display("FAIL da_wb: got %h expected FFFFFFF8", bus.wb_addr); end
        checks++; if (bus.reg_idx !== 4'd0 || bus.remaining !== 5'd3 || bus.pc_in_list !== 1'b0) begin
            errors++; $display("FAIL da_state: got idx=%0d rem=%0d pc=%b expected idx=0 rem=3 pc=0", bus.reg_idx, bus.remaining, bus.pc_in_list); end
        do_steps(1);
        checks++; if (bus.addr !== 32'h0 || bus.reg_idx !== 4'd1) begin
            errors++; $display("FAIL da_wrap_step: got addr=%h idx=%0d expected addr=0 idx=1", bus.addr, bus.reg_idx); end
        do_load(16'h0000, 1'b1, 1'b0, 32'h300, 1'b0);
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.remaining !== 5'd0) begin
            errors++; $display("FAIL empty_state: got busy=%b done=%b rem=%0d expected busy=0 done=1 rem=0", bus.busy, bus.done, bus.remaining); end
        checks++; if (bus.wb_addr !== 32'h300 || bus.addr !== 32'h300) begin
            errors++; $display("FAIL empty_addr: got wb=%h addr=%h expected wb=300 addr=300", bus.wb_addr, bus.addr); end
        do_load(16'h0000, 1'b0, 1'b1, 32'h300, 1'b0);
        checks++; if (bus.wb_addr !== 32'h300 || bus.addr !== 32'h300 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL empty_db: got wb=%h addr=%h busy=%b expected wb=300 addr=300 busy=0", bus.wb_addr, bus.addr, bus.busy); end
    endtask

    task automatic test_collision_idle_step;
        do_load(16'h00F0, 1'b1, 1'b0, 32'h100, 1'b0);
        do_steps(1);
        checks++; if (bus.reg_idx !== 4'd5 || bus.addr !== 32'h104) begin
            errors++; $display("FAIL col_pre: got idx=%0d addr=%h expected idx=5 addr=104", bus.reg_idx, bus.addr); end
        do_load(16'h0003, 1'b1, 1'b0, 32'h500, 1'b1);
        checks++; if (bus.reg_idx !== 4'd0) begin errors++; $display("FAIL col_idx: got %0d expected 0", bus.reg_idx); end
        checks++; if (bus.addr !== 32'h500) begin errors++; $display("FAIL col_addr: got %h expected 500", bus.addr); end
        checks++; if (bus.remaining !== 5'd2) begin errors++; $display("FAIL col_rem: got %0d expected 2", bus.remaining); end
        checks++; if (bus.wb_addr !== 32'h508) begin errors++; $display("FAIL col_wb: got %h expected 508", bus.wb_addr); end
        do_steps(2);
        checks++; if (bus.busy !== 1'b0 || bus.addr !== 32'h508) begin
            errors++; $display("FAIL col_end: got busy=%b addr=%h expected busy=0 addr=508", bus.busy, bus.addr); end
        do_steps(2);
        checks++; if (bus.addr !== 32'h508 || bus.remaining !== 5'd0 || bus.reg_idx !== 4'd0 || bus.done !== 1'b1) begin
            errors++; $display("FAIL idle_step: got addr=%h rem=%0d idx=%0d done=%b expected addr=508 rem=0 idx=0 done=1", bus.addr, bus.remaining, bus.reg_idx, bus.done); end
        checks++; if (bus.wb_addr !== 32'h508 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL idle_wb: got wb=%h busy=%b expected wb=508 busy=0", bus.wb_addr, bus.busy); end
    endtask

    task automatic test_reset_mid;
        do_load(16'h8003, 1'b1, 1'b0, 32'h700, 1'b0);
        do_steps(1);
        checks++; if (bus.reg_idx !== 4'd1 || bus.addr !== 32'h704 || bus.pc_in_list !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got idx=%0d addr=%h pc=%b expected idx=1 addr=704 pc=1", bus.reg_idx, bus.addr, bus.pc_in_list); end
        rst      = 1'b1;
        bus.step = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        bus.step = 1'b0;
        checks++; if (bus.addr !== 32'h0 || bus.wb_addr !== 32'h0) begin
            errors++; $display("FAIL mid_addr: got addr=%h wb=%h expected 0 0", bus.addr, bus.wb_addr); end
        checks++; if (bus.pc_in_list !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mid_ctl: got pc=%b done=%b busy=%b expected pc=0 done=1 busy=0", bus.pc_in_list, bus.done, bus.busy); end
        checks++; if (bus.remaining !== 5'd0 || bus.reg_idx !== 4'd0) begin
            errors++; $display("FAIL mid_mask: got rem=%0d idx=%0d expected 0 0", bus.remaining, bus.reg_idx); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.load      = 1'b0;
        bus.step      = 1'b0;
        bus.reg_list  = 16'h0;
        bus.up        = 1'b0;
        bus.pre       = 1'b0;
        bus.base_addr = 32'h0;
        @(negedge clk);
        test_reset();
        test_ia();
        test_db_pc();
        test_ib_full();
        test_da_wrap_empty();
        test_collision_idle_step();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
